// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state encoding, forward selects and the forward-select helper.
package pipeline_hazard_controller_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_e;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  function automatic logic [1:0] fwd_sel(input logic mem_we, input logic [4:0] mem_wr,
                                         input logic wb_we, input logic [4:0] wb_wr,
                                         input logic [4:0] src);
    return (mem_we && mem_wr != 5'd0 && mem_wr == src) ? FWD_MEM :
           (wb_we && wb_wr != 5'd0 && wb_wr == src) ? FWD_WB : FWD_REG;
  endfunction
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: pipeline-side hazard inputs and controller-side enables/flushes/forwards.
interface pipeline_hazard_controller_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
  logic id_uses_rt, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write, mem_redirect;
  logic pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect;
  logic [1:0] forward_a, forward_b;
  logic [CNT_W-1:0] stall_count, flush_count;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_write_reg,
           mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, mem_redirect,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect,
           forward_a, forward_b, stall_count, flush_count
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_reg_write, ex_write_reg,
           mem_reg_write, mem_write_reg, wb_reg_write, wb_write_reg, mem_redirect,
    output pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect,
           forward_a, forward_b, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller_forwarding_unit.sv
// forwarding_unit: ALU operand source selection; MEM result beats WB result, $0 never forwarded.
module forwarding_unit
  import pipeline_hazard_controller_pkg::*;
(
  input  logic       mem_reg_write_i,
  input  logic [4:0] mem_write_reg_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_write_reg_i,
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  output logic [1:0] forward_a_o,
  output logic [1:0] forward_b_o
);
  assign forward_a_o = fwd_sel(mem_reg_write_i, mem_write_reg_i, wb_reg_write_i, wb_write_reg_i, ex_rs_i);
  assign forward_b_o = fwd_sel(mem_reg_write_i, mem_write_reg_i, wb_reg_write_i, wb_write_reg_i, ex_rt_i);
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall / MEM-redirect squash sequencer with forwarding and event counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_controller_if.slave bus
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic load_use, redirect, stall, redirect_g, stall_g;
  logic [1:0] fa, fb;
  assign load_use = bus.ex_mem_read && bus.ex_reg_write && bus.ex_write_reg != 5'd0 &&
                    (bus.ex_write_reg == bus.id_rs || (bus.id_uses_rt && bus.ex_write_reg == bus.id_rt));
  // The cycle after a redirect, younger stages already hold bubbles, so both events are ignored.
  assign redirect = bus.mem_redirect && state_q != FLUSH;
  assign stall    = load_use && state_q == RUN && !redirect;
  always_comb begin
    state_d = redirect ? FLUSH : stall ? STALL : RUN;
    stall_d = (stall && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (redirect && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  forwarding_unit u_fwd (
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_write_reg_i (bus.mem_write_reg),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_write_reg_i  (bus.wb_write_reg),
    .ex_rs_i         (bus.ex_rs),
    .ex_rt_i         (bus.ex_rt),
    .forward_a_o     (fa),
    .forward_b_o     (fb)
  );
  // While reset is held the pipeline sees a free-running, unforwarded configuration.
  assign redirect_g      = redirect && reset;
  assign stall_g         = stall && reset;
  assign bus.pc_enable    = !stall_g;
  assign bus.if_id_enable = !stall_g;
  assign bus.if_id_flush  = redirect_g;
  assign bus.id_ex_flush  = redirect_g || stall_g;
  assign bus.ex_mem_flush = redirect_g;
  assign bus.pc_redirect  = redirect_g;
  assign bus.forward_a    = reset ? fa : FWD_REG;
  assign bus.forward_b    = reset ? fb : FWD_REG;
  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;
endmodule
